// File: rtl/qam_demapper_pkg.sv
// Shared constants for the QAM demapper FIFO controller: FSM encoding,
// default sizing and the channel-index width helper.
package qam_demapper_pkg;

   localparam int DEF_NUM_CH = 4;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // A single channel still needs a 1-bit index port
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/qam_demapper_multi_controller_if.sv
// FIFO-bank side of the demapper controller: per-channel flags in,
// write/read strobes, read index and clear out.
interface qam_demapper_multi_controller_if #(
   parameter int NUM_CH = qam_demapper_pkg::DEF_NUM_CH
) ();
   localparam int RD_W = qam_demapper_pkg::idx_w(NUM_CH);

   logic [NUM_CH-1:0] wfull;
   logic [NUM_CH-1:0] rdempty;
   logic [NUM_CH-1:0] wr_en;
   logic [NUM_CH-1:0] rd_en;
   logic [RD_W-1:0]   rd_ch;
   logic              aclr;
   logic              available;

   modport master (input wfull, rdempty,
                   output wr_en, rd_en, rd_ch, aclr, available);
   modport slave  (output wfull, rdempty,
                   input wr_en, rd_en, rd_ch, aclr, available);
endinterface

// File: rtl/qam_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from the channel
// after the last winner; the pointer moves only when the caller advances.
module qam_rr_arbiter
   import qam_demapper_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   localparam int IW    = idx_w(NUM_CH)
) (
   input  logic              dclk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [NUM_CH-1:0] grant,
   output logic [IW-1:0]     idx
);
   logic [IW-1:0] last;
   logic          found;
   int            c;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         c = (int'(last) + k) % NUM_CH;
         if (!found && req[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = IW'(c);
         end
      end
   end

   always_ff @(posedge dclk or negedge reset) begin
      if (!reset)       last <= IW'(NUM_CH - 1);
      else if (advance) last <= idx;
   end
endmodule

// File: rtl/qam_demapper_multi_controller.sv
// Frame controller for a bank of demapper FIFOs: broadcasts symbol writes to
// all non-full channels, then drains them round-robin until every FIFO is empty.
module qam_demapper_multi_controller
   import qam_demapper_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                              dclk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic                              sym_tick,
   input  logic                              read_enable,
   input  logic [CNT_W-1:0]                  frame_len,
   qam_demapper_multi_controller_if.master   fifo,
   output logic                              complete,
   output logic                              overflow,
   output logic [1:0]                        state
);
   localparam int RD_W = idx_w(NUM_CH);

   state_e            st;
   logic [CNT_W-1:0]  len_q, wr_cnt, wr_cnt_nx;
   logic [NUM_CH-1:0] wr_en_q, rd_en_q, gnt;
   logic [RD_W-1:0]   rd_ch_q, gnt_idx;
   logic              aclr_q, cmpl_q, ovf_q;
   logic              active, rd_go, tick_go, all_empty;

   assign all_empty = &fifo.rdempty;
   assign active    = enable && (st == ST_FILL || st == ST_DRAIN);
   assign rd_go     = active && read_enable && !all_empty;
   assign tick_go   = enable && (st == ST_FILL) && sym_tick;
   assign wr_cnt_nx = wr_cnt + 1'b1;

   qam_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .dclk    (dclk),
      .reset   (reset),
      .req     (~fifo.rdempty),
      .advance (rd_go),
      .grant   (gnt),
      .idx     (gnt_idx)
   );

   always_ff @(posedge dclk or negedge reset) begin
      if (!reset) begin
         st      <= ST_IDLE;
         len_q   <= '0;
         wr_cnt  <= '0;
         wr_en_q <= '0;
         rd_en_q <= '0;
         rd_ch_q <= '0;
         aclr_q  <= 1'b1;
         cmpl_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wr_en_q <= '0;
         rd_en_q <= '0;
         if (rd_go) begin
            rd_en_q <= gnt;
            rd_ch_q <= gnt_idx;
         end
         // Full channels lose this symbol but the frame count still advances
         if (tick_go) begin
            wr_en_q <= ~fifo.wfull;
            wr_cnt  <= wr_cnt_nx;
            if (|fifo.wfull) ovf_q <= 1'b1;
         end
         case (st)
            ST_IDLE: if (enable && frame_len != '0) begin
               st     <= ST_FILL;
               len_q  <= frame_len;
               wr_cnt <= '0;
               ovf_q  <= 1'b0;
               aclr_q <= 1'b0;
            end
            ST_FILL: if (!enable) begin
               st     <= ST_IDLE;
               aclr_q <= 1'b1;
               wr_cnt <= '0;
               len_q  <= '0;
            end else if (tick_go && wr_cnt_nx == len_q) begin
               st <= ST_DRAIN;
            end
            ST_DRAIN: if (!enable) begin
               st     <= ST_IDLE;
               aclr_q <= 1'b1;
               wr_cnt <= '0;
               len_q  <= '0;
            end else if (all_empty && rd_en_q == '0) begin
               st     <= ST_DONE;
               cmpl_q <= 1'b1;
            end
            ST_DONE: if (!enable) begin
               st     <= ST_IDLE;
               cmpl_q <= 1'b0;
               aclr_q <= 1'b1;
               wr_cnt <= '0;
               len_q  <= '0;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   assign fifo.wr_en     = wr_en_q;
   assign fifo.rd_en     = rd_en_q;
   assign fifo.rd_ch     = rd_ch_q;
   assign fifo.aclr      = aclr_q;
   assign fifo.available = !all_empty;
   assign complete       = cmpl_q;
   assign overflow       = ovf_q;
   assign state          = st;
endmodule

// File: doc/qam_demapper_multi_controller.md
QAM_DEMAPPER_MULTI_CONTROLLER -- requirements
Module: qam_demapper_multi_controller

Interface
REQ-001 Parameter NUM_CH, default 4: number of demapper channels/FIFOs, range 1..8.
REQ-002 Parameter CNT_W, default 16: width of the frame-length and symbol counters.
REQ-003 One clock and one reset, both as below; reset is asynchronous and active-low.
REQ-004 dclk  in  1  sole clock; all logic is rising-edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  run request; low returns the block to IDLE.
REQ-007 sym_tick  in  1  one-dclk pulse per received symbol.
REQ-008 read_enable  in  1  downstream ready to consume demapped data.
REQ-009 frame_len  in  CNT_W  symbols per channel per frame; sampled on IDLE->FILL.
REQ-010 wfull  in  NUM_CH  per-channel FIFO full flag.
REQ-011 rdempty  in  NUM_CH  per-channel FIFO empty flag.
REQ-012 wr_en  out  NUM_CH  per-channel FIFO write strobe.
REQ-013 rd_en  out  NUM_CH  one-hot-or-zero FIFO read strobe.
REQ-014 rd_ch  out  clog2(NUM_CH), min 1  index of the channel read this cycle.
REQ-015 aclr  out  1  FIFO clear.
REQ-016 available  out  1  high when any rdempty bit is low.
REQ-017 complete  out  1  frame finished.
REQ-018 overflow  out  1  sticky: a symbol was dropped because a FIFO was full.
REQ-019 state  out  2  current FSM state.

Function
REQ-020 States: IDLE=0, FILL=1, DRAIN=2, DONE=3.
REQ-021 IDLE: aclr=1; enable=1 and frame_len!=0 -> FILL next cycle; len_q<=frame_len, wr_cnt<=0; frame_len=0 stays in IDLE.
REQ-022 FILL: on sym_tick, wr_en[c]=1 in the next cycle for every c with wfull[c]=0 at the tick; wr_cnt increments by 1 per tick.
REQ-023 A tick with any wfull[c]=1 suppresses wr_en[c], sets overflow, and still increments wr_cnt.
REQ-024 FILL->DRAIN in the cycle after the tick at which wr_cnt reaches len_q; later ticks are ignored.
REQ-025 Reads in FILL and DRAIN: when read_enable=1 and at least one rdempty bit is 0, grant exactly one channel, registered, one-cycle rd_en pulse, rd_ch valid in the same cycle.
REQ-026 Grant order is round-robin, starting from the channel after the last grant; after reset the last grant is NUM_CH-1.
REQ-027 No grant when read_enable=0 or all rdempty bits are 1; rd_en=0 and rd_ch holds its value.
REQ-028 sym_tick and a read grant in the same cycle are both honoured independently.
REQ-029 DRAIN->DONE when all rdempty bits are 1 and no rd_en is outstanding that cycle.
REQ-030 DONE: complete=1, no writes or reads; enable=0 -> IDLE.
REQ-031 enable=0 in FILL or DRAIN -> IDLE next cycle; aclr=1 there; counters cleared; overflow held.
REQ-032 overflow clears only on reset or on the IDLE->FILL transition.
REQ-033 aclr, complete, and state are registered (Moore) outputs; available is combinational from rdempty.

Reset
REQ-034 While reset=0: state=IDLE, wr_en=0, rd_en=0, rd_ch=0, aclr=1, complete=0, overflow=0, counters=0, RR pointer=NUM_CH-1.
REQ-035 Reset asserted mid-FILL or mid-DRAIN aborts at once; no strobe is issued in the first cycle after release.

Structure
REQ-036 Package qam_demapper_pkg holds the state encoding constants and the default NUM_CH/CNT_W values.
REQ-037 Round-robin grant logic lives in sub-module qam_rr_arbiter (inputs: req, advance, clock, reset; outputs: one-hot grant and index).

Verification
REQ-038 NUM_CH=4, frame_len=3, no full, three ticks -> wr_en=4'b1111 three times, FILL->DRAIN after the third tick.
REQ-039 wfull=4'b0100 on the second tick -> wr_en=4'b1011 on that tick, overflow=1 until the next IDLE->FILL.
REQ-040 rdempty=4'b0000, read_enable=1 for 5 cycles -> rd_ch sequence 0,1,2,3,0 with one-hot rd_en.
REQ-041 In DRAIN, rdempty goes to 4'b1111 -> DONE next cycle, complete=1; enable=0 -> IDLE, aclr=1.
REQ-042 enable dropped mid-FILL, after one of three ticks -> IDLE next cycle, aclr=1; re-enable restarts with wr_cnt=0.
REQ-043 reset pulsed low mid-DRAIN -> all outputs reach REQ-034 values asynchronously, without waiting for a dclk edge.
